// File: rtl/nios2_onchip_dpram.sv
// nios2_onchip_dpram: true dual-port Avalon-MM on-chip RAM
// with post-reset zero fill, pipelined reads and collision flag.
module nios2_onchip_dpram #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 7,
   parameter int OUTREG    = 0,
   parameter int INIT_ZERO = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      s1_address,
   input  logic                   s1_chipselect,
   input  logic                   s1_read,
   input  logic                   s1_write,
   input  logic [DATA_W/8-1:0]    s1_byteenable,
   input  logic [DATA_W-1:0]      s1_writedata,
   output logic [DATA_W-1:0]      s1_readdata,
   output logic                   s1_readdatavalid,
   output logic                   s1_waitrequest,
   input  logic [ADDR_W-1:0]      s2_address,
   input  logic                   s2_chipselect,
   input  logic                   s2_read,
   input  logic                   s2_write,
   input  logic [DATA_W/8-1:0]    s2_byteenable,
   input  logic [DATA_W-1:0]      s2_writedata,
   output logic [DATA_W-1:0]      s2_readdata,
   output logic                   s2_readdatavalid,
   output logic                   s2_waitrequest,
   output logic                   collision
);
   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {INIT, READY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
   logic                busy;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [1:0]          rd_acc, wr_acc;
   logic                same_addr;
   logic [DATA_W-1:0]   nv [2];

   logic [1:0]          p_v_q, o_v_q;
   logic [DATA_W-1:0]   p_d_q [2];
   logic [DATA_W-1:0]   o_d_q [2];
   logic [1:0]          out_v;
   logic [DATA_W-1:0]   out_d [2];
   logic                coll_q;

   // state register: fill pointer and INIT/READY
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   // next state: walk the fill pointer to the last word
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      unique case (state_q)
         INIT: begin
            if (INIT_ZERO == 0 || init_addr_q == '1) begin
               state_d = READY;
            end else begin
               init_addr_d = init_addr_q + 1'b1;
            end
         end
         READY: ;
         default: state_d = INIT;
      endcase
   end

   // outputs of the FSM: stall both ports while filling
   always_comb begin
      busy           = (state_q == INIT);
      s1_waitrequest = busy;
      s2_waitrequest = busy;
   end

   assign wr_acc[0] = s1_chipselect & s1_write & ~busy;
   assign wr_acc[1] = s2_chipselect & s2_write & ~busy;
   assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~busy;
   assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~busy;
   assign same_addr = (s1_address == s2_address);

   // post-write word at each port address; s1 lanes override s2
   always_comb begin
      nv[0] = mem_q[s1_address];
      nv[1] = mem_q[s2_address];
      for (int b = 0; b < BE_W; b++) begin
         if (wr_acc[1] && s2_byteenable[b]) begin
            nv[1][b*8 +: 8] = s2_writedata[b*8 +: 8];
            if (same_addr) nv[0][b*8 +: 8] = s2_writedata[b*8 +: 8];
         end
         if (wr_acc[0] && s1_byteenable[b]) begin
            nv[0][b*8 +: 8] = s1_writedata[b*8 +: 8];
            if (same_addr) nv[1][b*8 +: 8] = s1_writedata[b*8 +: 8];
         end
      end
   end

   // array update: zero fill while busy, merged words when ready
   always_ff @(posedge clk) begin
      if (busy) begin
         if (INIT_ZERO != 0) mem_q[init_addr_q] <= '0;
      end else begin
         if (wr_acc[0]) mem_q[s1_address] <= nv[0];
         if (wr_acc[1]) mem_q[s2_address] <= nv[1];
      end
   end

   // read pipeline: capture merged word, then output stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_v_q  <= '0;
         o_v_q  <= '0;
         p_d_q  <= '{default: '0};
         o_d_q  <= '{default: '0};
         coll_q <= 1'b0;
      end else begin
         p_v_q  <= rd_acc;
         o_v_q  <= p_v_q;
         coll_q <= wr_acc[0] & wr_acc[1] & same_addr;
         for (int k = 0; k < 2; k++) begin
            if (rd_acc[k]) p_d_q[k] <= nv[k];
            if (p_v_q[k])  o_d_q[k] <= p_d_q[k];
         end
      end
   end

   if (OUTREG != 0) begin : g_oreg
      logic [1:0]        r_v_q;
      logic [DATA_W-1:0] r_d_q [2];
      // extra output register stage, data held between pulses
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_v_q <= '0;
            r_d_q <= '{default: '0};
         end else begin
            r_v_q <= o_v_q;
            for (int k = 0; k < 2; k++) begin
               if (o_v_q[k]) r_d_q[k] <= o_d_q[k];
            end
         end
      end
      assign out_v    = r_v_q;
      assign out_d[0] = r_d_q[0];
      assign out_d[1] = r_d_q[1];
   end else begin : g_noreg
      assign out_v    = o_v_q;
      assign out_d[0] = o_d_q[0];
      assign out_d[1] = o_d_q[1];
   end

   assign s1_readdatavalid = out_v[0];
   assign s2_readdatavalid = out_v[1];
   assign s1_readdata      = out_d[0];
   assign s2_readdata      = out_d[1];
   assign collision        = coll_q;

endmodule

// File: tb/tb_nios2_onchip_dpram.sv
// tb_nios2_onchip_dpram: scoreboard bench, two instances
// (OUTREG=0 and OUTREG=1) driven with identical stimulus.
module tb_nios2_onchip_dpram;
   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  a1, a2;
   logic        cs1, rd1, wr1, cs2, rd2, wr2;
   logic [3:0]  be1, be2;
   logic [31:0] wd1, wd2;

   logic [31:0] dA1, dA2, dB1, dB2;
   logic        vA1, vA2, vB1, vB2;
   logic        wA1, wA2, wB1, wB2;
   logic        cA, cB;

   always #5 clk = ~clk;

   nios2_onchip_dpram #(.OUTREG(0)) u_dut_a (
      .clk(clk), .reset(rst),
      .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
      .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
      .s1_readdata(dA1), .s1_readdatavalid(vA1),
      .s1_waitrequest(wA1),
      .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
      .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
      .s2_readdata(dA2), .s2_readdatavalid(vA2),
      .s2_waitrequest(wA2),
      .collision(cA)
   );

   nios2_onchip_dpram #(.OUTREG(1)) u_dut_b (
      .clk(clk), .reset(rst),
      .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1),
      .s1_write(wr1), .s1_byteenable(be1), .s1_writedata(wd1),
      .s1_readdata(dB1), .s1_readdatavalid(vB1),
      .s1_waitrequest(wB1),
      .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2),
      .s2_write(wr2), .s2_byteenable(be2), .s2_writedata(wd2),
      .s2_readdata(dB2), .s2_readdatavalid(vB2),
      .s2_waitrequest(wB2),
      .collision(cB)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq [4][$];
   logic [31:0] mm [128];
   int          ecnt = 0;
   int          fill = 0;
   int          coll_due = -1;
   bit          ready_m = 1'b0;
   int          errs = 0;
   int          nchk = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s @edge %0d: got %h want %h",
                  tag, ecnt, got, exp);
      end
   endtask

   task automatic model_edge();
      bit          w1, w2, r1, r2;
      logic [31:0] n1, n2;
      ecnt++;
      if (rst) return;
      w1 = ready_m && cs1 && wr1;
      w2 = ready_m && cs2 && wr2;
      r1 = ready_m && cs1 && rd1 && !wr1;
      r2 = ready_m && cs2 && rd2 && !wr2;
      n1 = mm[a1];
      n2 = mm[a2];
      for (int b = 0; b < 4; b++) begin
         if (w2 && be2[b]) begin
            n2[b*8 +: 8] = wd2[b*8 +: 8];
            if (a1 == a2) n1[b*8 +: 8] = wd2[b*8 +: 8];
         end
         if (w1 && be1[b]) begin
            n1[b*8 +: 8] = wd1[b*8 +: 8];
            if (a1 == a2) n2[b*8 +: 8] = wd1[b*8 +: 8];
         end
      end
      if (r1) begin
         sbq[0].push_back('{ecnt + 1, n1});
         sbq[2].push_back('{ecnt + 2, n1});
      end
      if (r2) begin
         sbq[1].push_back('{ecnt + 1, n2});
         sbq[3].push_back('{ecnt + 2, n2});
      end
      if (w1) mm[a1] = n1;
      if (w2) mm[a2] = n2;
      if (w1 && w2 && a1 == a2) coll_due = ecnt;
      if (!ready_m) begin
         fill++;
         if (fill == 128) ready_m = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      cs1 = 0; rd1 = 0; wr1 = 0; a1 = '0; be1 = '0; wd1 = '0;
      cs2 = 0; rd2 = 0; wr2 = 0; a2 = '0; be2 = '0; wd2 = '0;
   endtask

   task automatic rd(input int p, input logic [6:0] a);
      if (p == 1) begin
         cs1 = 1; rd1 = 1; wr1 = 0; a1 = a;
      end else begin
         cs2 = 1; rd2 = 1; wr2 = 0; a2 = a;
      end
   endtask

   task automatic wr(input int p, input logic [6:0] a,
                     input logic [31:0] d, input logic [3:0] be);
      if (p == 1) begin
         cs1 = 1; rd1 = 0; wr1 = 1; a1 = a; wd1 = d; be1 = be;
      end else begin
         cs2 = 1; rd2 = 0; wr2 = 1; a2 = a; wd2 = d; be2 = be;
      end
   endtask

   task automatic assert_rst();
      #2;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) sbq[k].delete();
      for (int i = 0; i < 128; i++) mm[i] = '0;
      ready_m  = 1'b0;
      fill     = 0;
      coll_due = -1;
   endtask

   task automatic fill_check(input string tag);
      for (int i = 1; i <= 128; i++) begin
         tick();
         if (i == 1 || i == 127 || i == 128) begin
            chk({tag, "_wA1"}, 32'(wA1), 32'(i < 128));
            chk({tag, "_wA2"}, 32'(wA2), 32'(i < 128));
            chk({tag, "_wB1"}, 32'(wB1), 32'(i < 128));
         end
      end
   endtask

   task automatic mon_port(input int k, input logic v,
                           input logic [31:0] d);
      bit e;
      e = (sbq[k].size() > 0) && (sbq[k][0].due == ecnt);
      if (e || v) begin
         chk($sformatf("rvalid%0d", k), 32'(v), 32'(e));
         if (e && v) chk($sformatf("rdata%0d", k), d, sbq[k][0].data);
         if (e) void'(sbq[k].pop_front());
      end
   endtask

   // compare DUT outputs against the scoreboard at every falling edge
   always @(negedge clk) begin
      bit ec;
      mon_port(0, vA1, dA1);
      mon_port(1, vA2, dA2);
      mon_port(2, vB1, dB1);
      mon_port(3, vB2, dB2);
      ec = (coll_due == ecnt);
      if (ec || cA) chk("collA", 32'(cA), 32'(ec));
      if (ec || cB) chk("collB", 32'(cB), 32'(ec));
   end

   initial begin
      idle();
      assert_rst();
      repeat (3) tick();
      chk("rst_wA1", 32'(wA1), 32'd1);
      chk("rst_wA2", 32'(wA2), 32'd1);
      chk("rst_wB2", 32'(wB2), 32'd1);
      chk("rst_dA1", dA1, 32'd0);
      chk("rst_dB2", dB2, 32'd0);
      chk("rst_vA1", 32'(vA1), 32'd0);
      chk("rst_col", 32'(cA), 32'd0);

      rst = 1'b0;
      rd(1, 7'd0);
      fill_check("fill");
      rd(1, 7'd0);   rd(2, 7'd127); tick();
      rd(1, 7'd64);  rd(2, 7'd64);  tick();
      rd(1, 7'd127); rd(2, 7'd0);   tick();
      idle(); repeat (3) tick();

      wr(1, 7'd5, 32'hAABBCCDD, 4'hF); tick();
      wr(1, 7'd5, 32'h11223344, 4'h5); tick();
      idle(); rd(2, 7'd5); tick();
      idle(); repeat (3) tick();
      chk("bytelane_model", mm[5], 32'hAA22CC44);

      wr(1, 7'd9, 32'h11111111, 4'h3);
      wr(2, 7'd9, 32'h22222222, 4'hF); tick();
      idle(); rd(1, 7'd9); tick();
      idle(); repeat (3) tick();
      chk("coll_model", mm[9], 32'h22221111);

      wr(2, 7'd3, 32'hDEADBEEF, 4'hF); rd(1, 7'd3); tick();
      wr(1, 7'd4, 32'hCAFEF00D, 4'h3); rd(2, 7'd4); tick();
      wr(1, 7'd20, 32'h01234567, 4'hF); tick();
      rd(1, 7'd20); tick();
      idle(); cs1 = 1; rd1 = 1; wr1 = 1; a1 = 7'd21;
      wd1 = 32'h5A5A5A5A; be1 = 4'hF; tick();
      idle(); rd(2, 7'd21); tick();
      idle(); repeat (3) tick();

      for (int i = 0; i < 8; i++) begin
         wr(1, 7'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
         tick();
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         rd(1, 7'(i)); rd(2, 7'(7 - i)); tick();
      end
      idle(); repeat (4) tick();

      for (int n = 0; n < 300; n++) begin
         cs1 = 1'($urandom); rd1 = 1'($urandom); wr1 = 1'($urandom);
         a1 = 7'($urandom_range(0, 15)); be1 = 4'($urandom);
         wd1 = $urandom;
         cs2 = 1'($urandom); rd2 = 1'($urandom); wr2 = 1'($urandom);
         a2 = 7'($urandom_range(0, 15)); be2 = 4'($urandom);
         wd2 = $urandom;
         tick();
      end
      idle(); repeat (4) tick();

      rd(2, 7'd3); tick();
      idle();
      assert_rst();
      repeat (2) tick();
      rst = 1'b0;
      fill_check("rst_inflight");

      rd(2, 7'd5);
      repeat (50) tick();
      assert_rst();
      repeat (2) tick();
      rst = 1'b0;
      fill_check("rst_fill");
      tick();
      rd(1, 7'd9); rd(2, 7'd3); tick();
      idle(); repeat (4) tick();

      for (int k = 0; k < 4; k++)
         chk($sformatf("sbq%0d_empty", k), 32'(sbq[k].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
